// File: rtl/motor_steer_pwm_if.sv
// Configuration strobe and waveform outputs shared between the register block
// side (master) and the motor/servo waveform generator (slave).
interface motor_steer_pwm_if;
  logic        cfg_valid;
  logic        cfg_enable;
  logic        cfg_dir;
  logic [15:0] cfg_duty;
  logic [20:0] cfg_steer;
  logic        motor_pwm;
  logic        motor_dir;
  logic        steer_pwm;
  logic        busy;

  modport master (
    output cfg_valid, cfg_enable, cfg_dir, cfg_duty, cfg_steer,
    input  motor_pwm, motor_dir, steer_pwm, busy
  );

  modport slave (
    input  cfg_valid, cfg_enable, cfg_dir, cfg_duty, cfg_steer,
    output motor_pwm, motor_dir, steer_pwm, busy
  );
endinterface

// File: rtl/motor_steer_pwm.sv
// Motor PWM with slew-limited duty and braked/dead-timed reversals, plus a
// servo pulse generator; all waveform changes land on period boundaries.
module motor_steer_pwm #(
  parameter int MOTOR_PERIOD = 5000,
  parameter int SERVO_PERIOD = 2000000,
  parameter int STEER_MIN    = 100000,
  parameter int STEER_MAX    = 200000,
  parameter int RAMP_STEP    = 50,
  parameter int DEAD_PERIODS = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  motor_steer_pwm_if.slave  bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_BRAKE = 2'd1,
    S_DEAD  = 2'd2
  } state_e;

  localparam logic [15:0] MP_FULL   = 16'(MOTOR_PERIOD);
  localparam logic [15:0] MP_LAST   = 16'(MOTOR_PERIOD - 1);
  localparam logic [20:0] SP_LAST   = 21'(SERVO_PERIOD - 1);
  localparam logic [20:0] S_MIN     = 21'(STEER_MIN);
  localparam logic [20:0] S_MAX     = 21'(STEER_MAX);
  localparam logic [20:0] S_MID     = 21'((STEER_MIN + STEER_MAX) / 2);
  localparam logic [15:0] STEP      = 16'(RAMP_STEP);
  localparam logic [15:0] DEAD_LOAD = 16'(DEAD_PERIODS - 1);

  // Saturate a requested high-time to the full period.
  function automatic logic [15:0] sat_duty(input logic [15:0] d);
    return (d > MP_FULL) ? MP_FULL : d;
  endfunction

  function automatic logic [20:0] clamp_steer(input logic [20:0] s);
    if (s < S_MIN) return S_MIN;
    if (s > S_MAX) return S_MAX;
    return s;
  endfunction

  // One slew step toward tgt; differences are only formed in the
  // direction that cannot wrap, and the step lands exactly on tgt.
  function automatic logic [15:0] ramp_toward(input logic [15:0] cur,
                                              input logic [15:0] tgt);
    if (cur < tgt) return ((tgt - cur) <= STEP) ? tgt : (cur + STEP);
    if (cur > tgt) return ((cur - tgt) <= STEP) ? tgt : (cur - STEP);
    return cur;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] mcnt_q, mcnt_d;
  logic [20:0] scnt_q, scnt_d;
  logic [15:0] duty_act_q, duty_act_d;
  logic        motor_dir_q, motor_dir_d;
  logic [15:0] dcnt_q, dcnt_d;
  logic        tgt_en_q, tgt_en_d;
  logic        tgt_dir_q, tgt_dir_d;
  logic [15:0] tgt_duty_q, tgt_duty_d;
  logic [20:0] tgt_steer_q, tgt_steer_d;
  logic [20:0] steer_act_q, steer_act_d;
  logic        motor_pwm_q, motor_pwm_d;
  logic        steer_pwm_q, steer_pwm_d;

  logic        m_bnd;
  logic        s_bnd;
  logic [15:0] eff_duty;

  assign m_bnd    = (mcnt_q == MP_LAST);
  assign s_bnd    = (scnt_q == SP_LAST);
  assign eff_duty = tgt_en_q ? tgt_duty_q : 16'd0;

  always_comb begin
    tgt_en_d    = tgt_en_q;
    tgt_dir_d   = tgt_dir_q;
    tgt_duty_d  = tgt_duty_q;
    tgt_steer_d = tgt_steer_q;
    if (bus.cfg_valid) begin
      tgt_en_d    = bus.cfg_enable;
      tgt_dir_d   = bus.cfg_dir;
      tgt_duty_d  = sat_duty(bus.cfg_duty);
      tgt_steer_d = clamp_steer(bus.cfg_steer);
    end
  end

  always_comb begin
    mcnt_d      = m_bnd ? 16'd0 : (mcnt_q + 16'd1);
    scnt_d      = s_bnd ? 21'd0 : (scnt_q + 21'd1);
    steer_act_d = s_bnd ? tgt_steer_q : steer_act_q;
    // Outputs trail the counters by one cycle so each period is whole.
    motor_pwm_d = (mcnt_q < duty_act_q);
    steer_pwm_d = (scnt_q < steer_act_q);
  end

  always_comb begin
    state_d     = state_q;
    duty_act_d  = duty_act_q;
    motor_dir_d = motor_dir_q;
    dcnt_d      = dcnt_q;
    if (m_bnd) begin
      unique case (state_q)
        S_RUN: begin
          if (tgt_dir_q == motor_dir_q) begin
            duty_act_d = ramp_toward(duty_act_q, eff_duty);
          end else begin
            state_d    = S_BRAKE;
            duty_act_d = ramp_toward(duty_act_q, 16'd0);
          end
        end
        S_BRAKE: begin
          if (tgt_dir_q == motor_dir_q) begin
            state_d    = S_RUN;
            duty_act_d = ramp_toward(duty_act_q, eff_duty);
          end else if (duty_act_q == 16'd0) begin
            state_d = S_DEAD;
            dcnt_d  = DEAD_LOAD;
          end else begin
            duty_act_d = ramp_toward(duty_act_q, 16'd0);
          end
        end
        S_DEAD: begin
          duty_act_d = 16'd0;
          if (dcnt_q == 16'd0) begin
            // Leaving dead time: flip direction and take the first ramp step.
            state_d     = S_RUN;
            motor_dir_d = tgt_dir_q;
            duty_act_d  = ramp_toward(16'd0, eff_duty);
          end else begin
            dcnt_d = dcnt_q - 16'd1;
          end
        end
        default: begin
          state_d    = S_RUN;
          duty_act_d = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_RUN;
      mcnt_q      <= 16'd0;
      scnt_q      <= 21'd0;
      duty_act_q  <= 16'd0;
      motor_dir_q <= 1'b0;
      dcnt_q      <= 16'd0;
      tgt_en_q    <= 1'b0;
      tgt_dir_q   <= 1'b0;
      tgt_duty_q  <= 16'd0;
      tgt_steer_q <= S_MID;
      steer_act_q <= S_MID;
      motor_pwm_q <= 1'b0;
      steer_pwm_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcnt_q      <= mcnt_d;
      scnt_q      <= scnt_d;
      duty_act_q  <= duty_act_d;
      motor_dir_q <= motor_dir_d;
      dcnt_q      <= dcnt_d;
      tgt_en_q    <= tgt_en_d;
      tgt_dir_q   <= tgt_dir_d;
      tgt_duty_q  <= tgt_duty_d;
      tgt_steer_q <= tgt_steer_d;
      steer_act_q <= steer_act_d;
      motor_pwm_q <= motor_pwm_d;
      steer_pwm_q <= steer_pwm_d;
    end
  end

  assign bus.motor_pwm = motor_pwm_q;
  assign bus.motor_dir = motor_dir_q;
  assign bus.steer_pwm = steer_pwm_q;
  assign bus.busy      = (state_q != S_RUN) || (duty_act_q != eff_duty) ||
                         (motor_dir_q != tgt_dir_q);

endmodule

// File: tb/tb_motor_steer_pwm.sv
// Directed bench for motor_steer_pwm: period high-times, reversal sequencing,
// servo clamping and reset/boundary corner cases against hand-computed values.
module tb_motor_steer_pwm;
  localparam int MP = 100;
  localparam int SP = 1000;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  motor_steer_pwm_if bus ();

  motor_steer_pwm #(
    .MOTOR_PERIOD(MP),
    .SERVO_PERIOD(SP),
    .STEER_MIN   (50),
    .STEER_MAX   (150),
    .RAMP_STEP   (10),
    .DEAD_PERIODS(2)
  ) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .bus   (bus)
  );

  always #5 ACLK = ~ACLK;

  // Edges since reset release; its value modulo the period marks period starts.
  int ecount;
  always @(posedge ACLK) begin
    if (ARESET) ecount <= 0;
    else        ecount <= ecount + 1;
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  int   glitches = 0;
  logic prev_dir = 1'b0;
  logic prev_pwm = 1'b0;
  int   hi, hi_m, d0, b0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic send_cfg(input logic en, input logic dir, input int duty, input int steer);
    bus.cfg_valid  = 1'b1;
    bus.cfg_enable = en;
    bus.cfg_dir    = dir;
    bus.cfg_duty   = 16'(duty);
    bus.cfg_steer  = 21'(steer);
    tick();
    bus.cfg_valid  = 1'b0;
  endtask

  task automatic align(input int n);
    while (ecount % n != 0) tick();
  endtask

  // Strobe at a period start; returns at the start of the first period using it.
  task automatic cfg_at_start(input logic en, input logic dir, input int duty, input int steer);
    align(MP);
    send_cfg(en, dir, duty, steer);
    repeat (MP - 1) tick();
  endtask

  task automatic measure_period(output int h, output int dir0, output int busy0);
    h = 0;
    dir0 = 0;
    busy0 = 0;
    for (int i = 0; i < MP; i++) begin
      tick();
      if (i == 0) begin
        dir0  = int'(bus.motor_dir);
        busy0 = int'(bus.busy);
      end
      if (bus.motor_pwm) h++;
      if (bus.motor_dir !== prev_dir && (bus.motor_pwm || prev_pwm)) glitches++;
      prev_dir = bus.motor_dir;
      prev_pwm = bus.motor_pwm;
    end
  endtask

  task automatic measure_frame(output int h);
    align(SP);
    h = 0;
    for (int i = 0; i < SP; i++) begin
      tick();
      if (bus.steer_pwm) h++;
    end
  endtask

  int rev_hi[7]   = '{20, 10, 0, 0, 0, 10, 20};
  int rev_dir[7]  = '{0, 0, 0, 0, 0, 1, 1};
  int rev_busy[7] = '{1, 1, 1, 1, 1, 1, 0};
  int up_hi[5]    = '{10, 20, 30, 35, 35};
  int up_busy[5]  = '{1, 1, 1, 0, 0};
  int dis_hi[4]   = '{20, 10, 0, 0};

  initial begin
    bus.cfg_valid  = 1'b0;
    bus.cfg_enable = 1'b0;
    bus.cfg_dir    = 1'b0;
    bus.cfg_duty   = '0;
    bus.cfg_steer  = '0;
    ARESET = 1'b1;
    repeat (3) tick();
    check_val("rst_motor_pwm", int'(bus.motor_pwm), 0);
    check_val("rst_motor_dir", int'(bus.motor_dir), 0);
    check_val("rst_busy",      int'(bus.busy),      0);
    check_val("rst_steer_pwm", int'(bus.steer_pwm), 0);

    // First frame after release: default mid-position pulse, motor idle.
    ARESET = 1'b0;
    hi = 0;
    hi_m = 0;
    for (int i = 0; i < SP; i++) begin
      tick();
      if (i == 0) check_val("steer_first_edge", int'(bus.steer_pwm), 1);
      if (bus.steer_pwm) hi++;
      if (bus.motor_pwm) hi_m++;
    end
    check_val("steer_default_width", hi, 100);
    check_val("motor_idle_width", hi_m, 0);

    // Ramp-up to 35.
    cfg_at_start(1'b1, 1'b0, 35, 100);
    for (int i = 0; i < 5; i++) begin
      measure_period(hi, d0, b0);
      check_val($sformatf("ramp_hi[%0d]", i), hi, up_hi[i]);
      check_val($sformatf("ramp_busy[%0d]", i), b0, up_busy[i]);
    end

    // Duty clamp: 500 saturates to a full period.
    cfg_at_start(1'b1, 1'b0, 500, 100);
    for (int i = 0; i < 8; i++) begin
      measure_period(hi, d0, b0);
      check_val($sformatf("clamp_hi[%0d]", i), hi, (35 + 10 * (i + 1) > 100) ? 100 : 35 + 10 * (i + 1));
    end
    check_val("clamp_busy", b0, 0);

    // Steer clamp low.
    send_cfg(1'b1, 1'b0, 500, 10);
    measure_frame(hi);
    check_val("steer_min_width", hi, 50);

    // Steer clamp high, written mid-frame: current frame keeps the old width.
    align(SP);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.steer_pwm) hi++;
    end
    send_cfg(1'b1, 1'b0, 500, 300);
    if (bus.steer_pwm) hi++;
    for (int i = 0; i < SP - 21; i++) begin
      tick();
      if (bus.steer_pwm) hi++;
    end
    check_val("steer_midframe_old", hi, 50);
    measure_frame(hi);
    check_val("steer_max_width", hi, 150);

    // Bring duty down to 30 in direction 0.
    cfg_at_start(1'b1, 1'b0, 30, 150);
    for (int i = 0; i < 7; i++) begin
      measure_period(hi, d0, b0);
      check_val($sformatf("down_hi[%0d]", i), hi, (100 - 10 * (i + 1) < 30) ? 30 : 100 - 10 * (i + 1));
    end

    // Reversal to dir 1, duty 20.
    glitches = 0;
    cfg_at_start(1'b1, 1'b1, 20, 150);
    for (int i = 0; i < 7; i++) begin
      measure_period(hi, d0, b0);
      check_val($sformatf("rev_hi[%0d]", i), hi, rev_hi[i]);
      check_val($sformatf("rev_dir[%0d]", i), d0, rev_dir[i]);
      check_val($sformatf("rev_busy[%0d]", i), b0, rev_busy[i]);
    end
    check_val("rev_no_pwm_on_dir_change", glitches, 0);

    // Disable from duty 30.
    cfg_at_start(1'b1, 1'b1, 30, 150);
    measure_period(hi, d0, b0);
    check_val("dis_pre_hi", hi, 30);
    cfg_at_start(1'b0, 1'b1, 30, 150);
    for (int i = 0; i < 4; i++) begin
      measure_period(hi, d0, b0);
      check_val($sformatf("dis_hi[%0d]", i), hi, dis_hi[i]);
    end
    check_val("dis_dir_kept", d0, 1);
    check_val("dis_busy", b0, 0);
    measure_frame(hi);
    check_val("dis_steer_width", hi, 150);

    // Strobe on the boundary cycle: deferred by one period.
    align(MP);
    repeat (MP - 1) tick();
    send_cfg(1'b1, 1'b1, 40, 150);
    measure_period(hi, d0, b0);
    check_val("bnd_deferred_hi", hi, 0);
    measure_period(hi, d0, b0);
    check_val("bnd_first_step", hi, 10);
    measure_period(hi, d0, b0);
    check_val("bnd_second_step", hi, 20);

    // Back-to-back strobes: last write wins.
    send_cfg(1'b1, 1'b1, 90, 150);
    send_cfg(1'b1, 1'b1, 15, 150);
    repeat (MP - 2) tick();
    measure_period(hi, d0, b0);
    check_val("b2b_step", hi, 20);
    measure_period(hi, d0, b0);
    check_val("b2b_final", hi, 15);

    // Reset in the middle of both pulses.
    align(SP);
    repeat (10) tick();
    check_val("pre_rst_motor_pwm", int'(bus.motor_pwm), 1);
    check_val("pre_rst_steer_pwm", int'(bus.steer_pwm), 1);
    ARESET = 1'b1;
    tick();
    check_val("mid_rst_motor_pwm", int'(bus.motor_pwm), 0);
    check_val("mid_rst_steer_pwm", int'(bus.steer_pwm), 0);
    check_val("mid_rst_motor_dir", int'(bus.motor_dir), 0);
    check_val("mid_rst_busy",      int'(bus.busy),      0);
    ARESET = 1'b0;
    hi = 0;
    hi_m = 0;
    for (int i = 0; i < SP; i++) begin
      tick();
      if (i == 0) check_val("post_rst_steer_first", int'(bus.steer_pwm), 1);
      if (bus.steer_pwm) hi++;
      if (bus.motor_pwm) hi_m++;
    end
    check_val("post_rst_steer_width", hi, 100);
    check_val("post_rst_motor_width", hi_m, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
